// File: rtl/solve_linear_3x3.sv
// Cramer's-rule solver for a signed 3x3 system A*x = b.
// Cofactors and determinants are formed at full precision over two cycles, then one
// restoring divider per channel (sharing the divisor |det(A)|) produces FRAC_BITS of
// fixed-point fraction. Results are sign-corrected, saturated and held until accepted.
module solve_linear_3x3 #(
   parameter int unsigned IN_W      = 9,
   parameter int unsigned FRAC_BITS = 8,
   parameter int unsigned OUT_W     = 16
) (
   input  logic             iclk,
   input  logic             irst_n,
   input  logic             ivalid,
   output logic             oready,
   input  logic [IN_W-1:0]  iData_a11,
   input  logic [IN_W-1:0]  iData_a12,
   input  logic [IN_W-1:0]  iData_a13,
   input  logic [IN_W-1:0]  iData_a21,
   input  logic [IN_W-1:0]  iData_a22,
   input  logic [IN_W-1:0]  iData_a23,
   input  logic [IN_W-1:0]  iData_a31,
   input  logic [IN_W-1:0]  iData_a32,
   input  logic [IN_W-1:0]  iData_a33,
   input  logic [IN_W-1:0]  iData_b1,
   input  logic [IN_W-1:0]  iData_b2,
   input  logic [IN_W-1:0]  iData_b3,
   output logic             ovalid,
   input  logic             iready,
   output logic [OUT_W-1:0] odata_x1,
   output logic [OUT_W-1:0] odata_x2,
   output logic [OUT_W-1:0] odata_x3,
   output logic             osingular,
   output logic             osat
);

   localparam int unsigned DET_W = 3 * IN_W + 3;
   localparam int unsigned N_DIV = DET_W + FRAC_BITS;
   localparam int unsigned MIN_W = 2 * IN_W + 1;
   localparam int unsigned CNT_W = $clog2(N_DIV);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_DIV - 1);
   localparam logic [N_DIV-1:0] QMAX = {{(N_DIV - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

   typedef enum logic [2:0] {StIdle, StMinor, StDet, StDiv, StFin, StDone} state_e;

   state_e state_q, state_d;

   // Operands, row-major: a_q[0]=a11 .. a_q[8]=a33
   logic signed [IN_W-1:0]  a_q   [9];
   logic signed [IN_W-1:0]  b_q   [3];
   logic signed [MIN_W-1:0] cof_q [9];
   logic [DET_W-1:0]        den_q;
   logic                    neg_q [3];
   logic [DET_W-1:0]        rem_q [3];
   logic [N_DIV-1:0]        nq_q  [3];   // numerator shifts out the top, quotient shifts in
   logic [CNT_W-1:0]        cnt_q;
   logic [OUT_W-1:0]        x_q   [3];
   logic                    valid_q, sing_q, sat_q;

   logic [IN_W-1:0]         a_in  [9];
   logic [IN_W-1:0]         b_in  [3];
   logic signed [MIN_W-1:0] ax    [9];
   logic signed [MIN_W-1:0] cof_d [9];
   logic signed [DET_W-1:0] ay    [3];
   logic signed [DET_W-1:0] by    [3];
   logic signed [DET_W-1:0] cx    [9];
   logic signed [DET_W-1:0] det_d;
   logic signed [DET_W-1:0] num_d [3];
   logic [DET_W-1:0]        det_abs;
   logic [DET_W-1:0]        num_abs [3];
   logic [DET_W:0]          rem_sh  [3];
   logic [DET_W:0]          diff    [3];
   logic [DET_W-1:0]        rem_nx  [3];
   logic [N_DIV-1:0]        nq_nx   [3];
   logic [OUT_W-1:0]        mag     [3];
   logic [OUT_W-1:0]        x_fin   [3];
   logic                    clamp   [3];

   assign a_in = '{iData_a11, iData_a12, iData_a13, iData_a21, iData_a22, iData_a23,
                   iData_a31, iData_a32, iData_a33};
   assign b_in = '{iData_b1, iData_b2, iData_b3};

   assign oready    = (state_q == StIdle);
   assign ovalid    = valid_q;
   assign osingular = sing_q;
   assign osat      = sat_q;
   assign odata_x1  = x_q[0];
   assign odata_x2  = x_q[1];
   assign odata_x3  = x_q[2];

   // Signed cofactors C(r,c) of A; C(r,c) at index r*3+c
   always_comb begin
      for (int i = 0; i < 9; i++) ax[i] = MIN_W'(a_q[i]);
      cof_d[0] = ax[4] * ax[8] - ax[5] * ax[7];
      cof_d[1] = ax[5] * ax[6] - ax[3] * ax[8];
      cof_d[2] = ax[3] * ax[7] - ax[4] * ax[6];
      cof_d[3] = ax[2] * ax[7] - ax[1] * ax[8];
      cof_d[4] = ax[0] * ax[8] - ax[2] * ax[6];
      cof_d[5] = ax[1] * ax[6] - ax[0] * ax[7];
      cof_d[6] = ax[1] * ax[5] - ax[2] * ax[4];
      cof_d[7] = ax[2] * ax[3] - ax[0] * ax[5];
      cof_d[8] = ax[0] * ax[4] - ax[1] * ax[3];
   end

   // det(A) along row 1; Di expanded along the replaced column, reusing A's cofactors
   always_comb begin
      for (int i = 0; i < 9; i++) cx[i] = DET_W'(cof_q[i]);
      for (int i = 0; i < 3; i++) begin
         ay[i] = DET_W'(a_q[i]);
         by[i] = DET_W'(b_q[i]);
      end
      det_d = ay[0] * cx[0] + ay[1] * cx[1] + ay[2] * cx[2];
      for (int c = 0; c < 3; c++) begin
         num_d[c] = by[0] * cx[c] + by[1] * cx[3 + c] + by[2] * cx[6 + c];
      end
      det_abs = det_d[DET_W-1] ? DET_W'(-det_d) : DET_W'(det_d);
      for (int c = 0; c < 3; c++) begin
         num_abs[c] = num_d[c][DET_W-1] ? DET_W'(-num_d[c]) : DET_W'(num_d[c]);
      end
   end

   // One restoring-divide step per channel, plus sign correction and symmetric saturation
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         rem_sh[c] = {rem_q[c], nq_q[c][N_DIV-1]};
         diff[c]   = rem_sh[c] - {1'b0, den_q};
         rem_nx[c] = diff[c][DET_W] ? rem_sh[c][DET_W-1:0] : diff[c][DET_W-1:0];
         nq_nx[c]  = {nq_q[c][N_DIV-2:0], ~diff[c][DET_W]};
         clamp[c]  = (nq_q[c] > QMAX);
         mag[c]    = clamp[c] ? QMAX[OUT_W-1:0] : nq_q[c][OUT_W-1:0];
         x_fin[c]  = neg_q[c] ? OUT_W'(-mag[c]) : mag[c];
      end
   end

   // FSM state register
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) state_q <= StIdle;
      else         state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (ivalid) state_d = StMinor;
         StMinor: state_d = StDet;
         StDet:   state_d = (det_d == '0) ? StDone : StDiv;
         StDiv:   if (cnt_q == '0) state_d = StFin;
         StFin:   state_d = StDone;
         StDone:  if (iready) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge iclk or negedge irst_n) begin
      if (!irst_n) begin
         for (int i = 0; i < 9; i++) begin
            a_q[i]   <= '0;
            cof_q[i] <= '0;
         end
         for (int c = 0; c < 3; c++) begin
            b_q[c]   <= '0;
            neg_q[c] <= 1'b0;
            rem_q[c] <= '0;
            nq_q[c]  <= '0;
            x_q[c]   <= '0;
         end
         den_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         sing_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (ivalid) begin
                  for (int i = 0; i < 9; i++) a_q[i] <= signed'(a_in[i]);
                  for (int c = 0; c < 3; c++) b_q[c] <= signed'(b_in[c]);
                  sing_q <= 1'b0;
                  sat_q  <= 1'b0;
               end
            end
            StMinor: begin
               for (int i = 0; i < 9; i++) cof_q[i] <= cof_d[i];
            end
            StDet: begin
               den_q <= det_abs;
               cnt_q <= CNT_INIT;
               for (int c = 0; c < 3; c++) begin
                  neg_q[c] <= num_d[c][DET_W-1] ^ det_d[DET_W-1];
                  rem_q[c] <= '0;
                  nq_q[c]  <= {num_abs[c], {FRAC_BITS{1'b0}}};
               end
               if (det_d == '0) begin
                  for (int c = 0; c < 3; c++) x_q[c] <= '0;
                  sing_q  <= 1'b1;
                  sat_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            StDiv: begin
               for (int c = 0; c < 3; c++) begin
                  rem_q[c] <= rem_nx[c];
                  nq_q[c]  <= nq_nx[c];
               end
               cnt_q <= cnt_q - 1'b1;
            end
            StFin: begin
               for (int c = 0; c < 3; c++) x_q[c] <= x_fin[c];
               sat_q   <= clamp[0] | clamp[1] | clamp[2];
               valid_q <= 1'b1;
            end
            StDone: begin
               if (iready) valid_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_solve_linear_3x3.sv
// Directed bench for solve_linear_3x3: table of hand-computed problems plus backpressure
// and mid-solve reset sequences.
module tb_solve_linear_3x3;

   logic        iclk = 1'b0;
   logic        irst_n = 1'b0;
   logic        ivalid = 1'b0;
   logic        iready = 1'b0;
   logic        oready, ovalid, osingular, osat;
   logic [8:0]  a_in [9];
   logic [8:0]  b_in [3];
   logic [15:0] x1, x2, x3;

   int checks = 0;
   int failures = 0;

   always #5 iclk = ~iclk;

   solve_linear_3x3 dut (
      .iclk      (iclk),
      .irst_n    (irst_n),
      .ivalid    (ivalid),
      .oready    (oready),
      .iData_a11 (a_in[0]),
      .iData_a12 (a_in[1]),
      .iData_a13 (a_in[2]),
      .iData_a21 (a_in[3]),
      .iData_a22 (a_in[4]),
      .iData_a23 (a_in[5]),
      .iData_a31 (a_in[6]),
      .iData_a32 (a_in[7]),
      .iData_a33 (a_in[8]),
      .iData_b1  (b_in[0]),
      .iData_b2  (b_in[1]),
      .iData_b3  (b_in[2]),
      .ovalid    (ovalid),
      .iready    (iready),
      .odata_x1  (x1),
      .odata_x2  (x2),
      .odata_x3  (x3),
      .osingular (osingular),
      .osat      (osat)
   );

   typedef struct packed {
      logic [8:0][8:0]  a;
      logic [2:0][8:0]  b;
      logic [2:0][15:0] x;
      logic             sing;
      logic             sat;
      logic [7:0]       lat;
   } vec_t;

   function automatic vec_t mk(input int a11, a12, a13, a21, a22, a23, a31, a32, a33,
                               input int b1, b2, b3, input int e1, e2, e3,
                               input int sing, sat, lat);
      vec_t v;
      v.a[0] = 9'(a11); v.a[1] = 9'(a12); v.a[2] = 9'(a13);
      v.a[3] = 9'(a21); v.a[4] = 9'(a22); v.a[5] = 9'(a23);
      v.a[6] = 9'(a31); v.a[7] = 9'(a32); v.a[8] = 9'(a33);
      v.b[0] = 9'(b1);  v.b[1] = 9'(b2);  v.b[2] = 9'(b3);
      v.x[0] = 16'(e1); v.x[1] = 16'(e2); v.x[2] = 16'(e3);
      v.sing = sing[0];
      v.sat  = sat[0];
      v.lat  = 8'(lat);
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one problem, measure latency, optionally stall the result for 'hold' cycles
   task automatic run_vec(input vec_t v, input string tag, input int hold);
      int edges;
      bit got;
      @(negedge iclk);
      for (int i = 0; i < 9; i++) a_in[i] = v.a[i];
      for (int i = 0; i < 3; i++) b_in[i] = v.b[i];
      ivalid = 1'b1;
      iready = 1'b0;
      edges  = 0;
      got    = 1'b0;
      while (!got && edges < 100) begin
         @(posedge iclk);
         #1;
         edges++;
         if (edges == 1) begin
            ivalid = 1'b0;
            for (int i = 0; i < 9; i++) a_in[i] = 9'h155;
            check({tag, " oready_busy"}, int'(oready), 0);
         end
         if (ovalid) got = 1'b1;
      end
      check({tag, " latency"}, edges, int'(v.lat));
      check({tag, " x1"}, int'($signed(x1)), int'($signed(v.x[0])));
      check({tag, " x2"}, int'($signed(x2)), int'($signed(v.x[1])));
      check({tag, " x3"}, int'($signed(x3)), int'($signed(v.x[2])));
      check({tag, " singular"}, int'(osingular), int'(v.sing));
      check({tag, " sat"}, int'(osat), int'(v.sat));
      if (hold > 0) begin
         ivalid = 1'b1;  // ignored outside idle
         for (int k = 0; k < hold; k++) begin
            @(posedge iclk);
            #1;
            check({tag, " hold_valid"}, int'(ovalid), 1);
            check({tag, " hold_oready"}, int'(oready), 0);
            check({tag, " hold_x1"}, int'($signed(x1)), int'($signed(v.x[0])));
            check({tag, " hold_x3"}, int'($signed(x3)), int'($signed(v.x[2])));
            check({tag, " hold_sing"}, int'(osingular), int'(v.sing));
         end
      end
      @(negedge iclk);
      ivalid = 1'b0;
      iready = 1'b1;
      @(posedge iclk);
      #1;
      check({tag, " valid_drop"}, int'(ovalid), 0);
      check({tag, " oready_back"}, int'(oready), 1);
      iready = 1'b0;
   endtask

   vec_t vecs [8];

   initial begin
      int seen;
      vecs[0] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 2, 3, 256, 512, 768, 0, 0, 42);
      vecs[1] = mk(2, 0, 0, 0, -4, 0, 0, 0, 8, 1, 1, 1, 128, -64, 32, 0, 0, 42);
      vecs[2] = mk(3, 0, 0, 0, 3, 0, 0, 0, 3, 1, -1, 2, 85, -85, 170, 0, 0, 42);
      vecs[3] = mk(1, 2, 3, 2, 4, 6, 0, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 3);
      vecs[4] = mk(1, 0, 0, 0, 1, 0, 0, 0, 1, 255, -256, 0, 32767, -32767, 0, 0, 1, 42);
      vecs[5] = mk(-256, 0, 0, 0, -256, 0, 0, 0, -256, -256, 0, 0, 256, 0, 0, 0, 0, 42);
      vecs[6] = mk(2, 1, 0, 1, 3, 1, 0, 1, 4, 1, 2, 3, 85, 85, 170, 0, 0, 42);
      vecs[7] = mk(1, 2, 0, 0, 1, 0, 0, 0, -1, 5, 2, 3, 256, 512, -768, 0, 0, 42);

      for (int i = 0; i < 9; i++) a_in[i] = '0;
      for (int i = 0; i < 3; i++) b_in[i] = '0;

      #1;
      check("reset ovalid", int'(ovalid), 0);
      check("reset oready", int'(oready), 1);
      check("reset x1", int'(x1), 0);
      check("reset flags", int'({osingular, osat}), 0);
      repeat (2) @(negedge iclk);
      irst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 0);

      // Backpressure: hold result for 10 cycles
      run_vec(vecs[6], "backpressure", 10);

      // Mid-solve reset: abort while dividing
      @(negedge iclk);
      for (int i = 0; i < 9; i++) a_in[i] = vecs[0].a[i];
      for (int i = 0; i < 3; i++) b_in[i] = vecs[0].b[i];
      ivalid = 1'b1;
      @(posedge iclk);
      #1;
      ivalid = 1'b0;
      repeat (20) @(posedge iclk);
      @(negedge iclk);
      irst_n = 1'b0;
      #1;
      check("midreset ovalid", int'(ovalid), 0);
      check("midreset x1", int'(x1), 0);
      check("midreset x2", int'(x2), 0);
      check("midreset x3", int'(x3), 0);
      check("midreset flags", int'({osingular, osat}), 0);
      @(negedge iclk);
      irst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge iclk);
         #1;
         if (ovalid) seen++;
      end
      check("midreset no_result", seen, 0);
      check("midreset oready", int'(oready), 1);

      run_vec(vecs[1], "after_reset", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
